// File: rtl/trace_tx_fifo.sv
// Elastic FWFT byte FIFO between the trace packet splitter and the UART transmitter.
// Read path is BRAM read register -> output register, plus a stretched stall indicator.

module trace_tx_fifo #(
   parameter int DEPTH_LOG2   = 8,
   parameter int HIWATER      = 192,
   parameter int STRETCH_LOG2 = 20
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                sync,
   input  logic                in_avail,
   input  logic [7:0]          in_data,
   output logic                in_next,
   output logic                out_avail,
   output logic [7:0]          out_data,
   input  logic                out_next,
   output logic [DEPTH_LOG2:0] level,
   output logic                hiwater,
   output logic                stall
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int PTR_W = DEPTH_LOG2 + 1;

   logic [7:0]              mem [DEPTH];
   logic [7:0]              mid_data_q;

   logic [PTR_W-1:0]        wptr_q, wptr_d;
   logic [PTR_W-1:0]        rptr_q, rptr_d;
   logic [PTR_W-1:0]        level_q, level_d;
   logic                    mid_vld_q, mid_vld_d;
   logic                    out_vld_q, out_vld_d;
   logic [7:0]              out_data_q, out_data_d;
   logic                    hiwater_q, hiwater_d;
   logic                    stall_q, stall_d;
   logic [STRETCH_LOG2-1:0] stretch_q, stretch_d;

   logic full;
   logic push;
   logic pop;
   logic ram_empty;
   logic out_free;
   logic mid_move;
   logic mid_free;
   logic ram_rd;
   logic blocked;

   // rptr tracks what has left the RAM, so RAM occupancy is wptr - rptr, not level
   assign full      = (level_q == PTR_W'(DEPTH));
   assign push      = in_avail & ~full & sync;
   assign pop       = out_next & out_vld_q & sync;
   assign ram_empty = (rptr_q == wptr_q);
   assign out_free  = ~out_vld_q | pop;
   assign mid_move  = mid_vld_q & out_free;
   assign mid_free  = ~mid_vld_q | mid_move;
   assign ram_rd    = mid_free & ~ram_empty & sync;
   assign blocked   = in_avail & full & sync;

   assign in_next   = push;
   assign out_avail = out_vld_q;
   assign out_data  = out_data_q;
   assign level     = level_q;
   assign hiwater   = hiwater_q;
   assign stall     = stall_q;

   always_ff @(posedge clk) begin
      if (push) mem[wptr_q[DEPTH_LOG2-1:0]] <= in_data;
   end

   always_ff @(posedge clk) begin
      if (ram_rd) mid_data_q <= mem[rptr_q[DEPTH_LOG2-1:0]];
   end

   always_comb begin
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      level_d    = level_q;
      mid_vld_d  = mid_vld_q;
      out_vld_d  = out_vld_q;
      out_data_d = out_data_q;

      if (push)   wptr_d = wptr_q + PTR_W'(1);
      if (ram_rd) rptr_d = rptr_q + PTR_W'(1);

      if (push & ~pop)      level_d = level_q + PTR_W'(1);
      else if (~push & pop) level_d = level_q - PTR_W'(1);

      if (ram_rd)        mid_vld_d = 1'b1;
      else if (mid_move) mid_vld_d = 1'b0;

      if (mid_move) begin
         out_vld_d  = 1'b1;
         out_data_d = mid_data_q;
      end else if (pop) begin
         out_vld_d  = 1'b0;
      end

      // Loss of trace sync discards everything queued; the stall stretch survives
      if (!sync) begin
         wptr_d     = '0;
         rptr_d     = '0;
         level_d    = '0;
         mid_vld_d  = 1'b0;
         out_vld_d  = 1'b0;
         out_data_d = '0;
      end

      hiwater_d = (level_q >= PTR_W'(HIWATER));

      if (blocked)                stretch_d = '1;
      else if (stretch_q != '0)   stretch_d = stretch_q - STRETCH_LOG2'(1);
      else                        stretch_d = stretch_q;

      stall_d = blocked | (stretch_q != '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         level_q    <= '0;
         mid_vld_q  <= 1'b0;
         out_vld_q  <= 1'b0;
         out_data_q <= '0;
         hiwater_q  <= 1'b0;
         stall_q    <= 1'b0;
         stretch_q  <= '0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         level_q    <= level_d;
         mid_vld_q  <= mid_vld_d;
         out_vld_q  <= out_vld_d;
         out_data_q <= out_data_d;
         hiwater_q  <= hiwater_d;
         stall_q    <= stall_d;
         stretch_q  <= stretch_d;
      end
   end

endmodule

// File: tb/tb_trace_tx_fifo.sv
// Directed bench for trace_tx_fifo: latency, streaming, full/stall, random wrap, flush, async reset.
// Inputs change and outputs are sampled 2-3 time units after each rising edge.

module tb_trace_tx_fifo;

   logic       clk;
   logic       rst;
   logic       sync;
   logic       in_avail;
   logic [7:0] in_data;
   logic       in_next;
   logic       out_avail;
   logic [7:0] out_data;
   logic       out_next;
   logic [8:0] level;
   logic       hiwater;
   logic       stall;

   int checks   = 0;
   int failures = 0;

   logic [7:0] sb[$];

   trace_tx_fifo #(
      .DEPTH_LOG2  (8),
      .HIWATER     (192),
      .STRETCH_LOG2(4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .sync     (sync),
      .in_avail (in_avail),
      .in_data  (in_data),
      .in_next  (in_next),
      .out_avail(out_avail),
      .out_data (out_data),
      .out_next (out_next),
      .level    (level),
      .hiwater  (hiwater),
      .stall    (stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   // Pops until the scoreboard is empty, comparing every byte in order
   task automatic drain(input string tag);
      out_next = 1'b1;
      in_avail = 1'b0;
      for (int n = 0; n < 600 && sb.size() != 0; n++) begin
         settle();
         if (out_avail) begin
            check(tag, out_data, sb[0]);
            void'(sb.pop_front());
         end
         tick();
      end
      out_next = 1'b0;
      check({tag, "_done"}, sb.size(), 0);
      check({tag, "_empty"}, out_avail, 1'b0);
   endtask

   initial begin
      int sent;
      int recv;
      int pushed;
      int pa;
      int pb;
      bit started;

      rst      = 1'b0;
      sync     = 1'b1;
      in_avail = 1'b0;
      in_data  = 8'h00;
      out_next = 1'b0;
      repeat (2) @(posedge clk);
      #2;

      // reset state
      check("rst_level",    level,     9'd0);
      check("rst_avail",    out_avail, 1'b0);
      check("rst_data",     out_data,  8'h00);
      check("rst_hiwater",  hiwater,   1'b0);
      check("rst_stall",    stall,     1'b0);
      rst = 1'b1;
      tick();

      // single byte latency: written at edge N, visible after N+2
      in_avail = 1'b1;
      in_data  = 8'hA5;
      settle();
      check("lat_in_next", in_next, 1'b1);
      tick();
      in_avail = 1'b0;
      check("lat_n0_avail", out_avail, 1'b0);
      check("lat_n0_level", level, 9'd1);
      tick();
      check("lat_n1_avail", out_avail, 1'b0);
      tick();
      check("lat_n2_avail", out_avail, 1'b1);
      check("lat_n2_data",  out_data,  8'hA5);
      check("lat_n2_level", level,     9'd1);
      out_next = 1'b1;
      tick();
      check("lat_pop_avail", out_avail, 1'b0);
      check("lat_pop_level", level,     9'd0);
      tick();
      out_next = 1'b0;
      check("empty_pop_level", level, 9'd0);
      check("lat_hiwater", hiwater, 1'b0);

      // streaming 0x00..0xFF while popping every cycle
      sent     = 0;
      recv     = 0;
      started  = 1'b0;
      out_next = 1'b1;
      for (int cyc = 0; cyc < 300 && recv < 256; cyc++) begin
         in_avail = (sent < 256);
         in_data  = sent[7:0];
         settle();
         if (in_next) sent++;
         tick();
         if (started) check("stream_gap", out_avail, 1'b1);
         if (out_avail) begin
            started = 1'b1;
            check("stream_data", out_data, recv[7:0]);
            recv++;
         end
         if (cyc >= 2 && cyc <= 255) check("stream_level", level, 9'd3);
      end
      check("stream_count", recv, 256);
      in_avail = 1'b0;
      tick();
      out_next = 1'b0;
      check("stream_end_level", level, 9'd0);
      check("stream_end_avail", out_avail, 1'b0);

      // fill to full with no pops
      for (int i = 0; i < 256; i++) begin
         in_avail = 1'b1;
         in_data  = i[7:0] ^ 8'h5A;
         sb.push_back(in_data);
         tick();
         if (i == 191) begin
            check("fill_lvl192", level, 9'd192);
            check("fill_hw_lag", hiwater, 1'b0);
         end
         if (i == 192) check("fill_hw_set", hiwater, 1'b1);
      end
      settle();
      check("full_level",   level,   9'd256);
      check("full_in_next", in_next, 1'b0);
      tick();
      tick();
      check("full_level_hold", level, 9'd256);
      check("full_stall", stall, 1'b1);
      check("full_head",  out_data, sb[0]);
      out_next = 1'b1;
      tick();
      void'(sb.pop_front());
      out_next = 1'b0;
      settle();
      check("unfull_in_next", in_next, 1'b1);
      in_avail = 1'b0;
      check("unfull_level", level, 9'd255);
      check("unfull_head",  out_data, sb[0]);
      for (int j = 1; j <= 16; j++) begin
         tick();
         check("stall_stretch", stall, (j <= 15) ? 1'b1 : 1'b0);
      end
      check("unfull_hiwater", hiwater, 1'b1);
      drain("fill_drain");

      // random duty streaming with pointer wrap
      pushed = 0;
      pa     = 50;
      pb     = 50;
      for (int cyc = 0; cyc < 20000 && pushed < 1000; cyc++) begin
         if (cyc % 100 == 0) begin
            pa = $urandom_range(90, 10);
            pb = $urandom_range(90, 10);
         end
         check("rnd_level", level, sb.size());
         if (sb.size() == 0) check("rnd_avail_empty", out_avail, 1'b0);
         in_avail = ($urandom_range(100, 1) <= pa);
         in_data  = 8'($urandom);
         out_next = ($urandom_range(100, 1) <= pb);
         settle();
         check("rnd_in_next", in_next, in_avail && (sb.size() != 256));
         if (out_next && out_avail) begin
            check("rnd_data", out_data, sb[0]);
            void'(sb.pop_front());
         end
         if (in_next) begin
            sb.push_back(in_data);
            pushed++;
         end
         tick();
      end
      check("rnd_pushed", pushed, 1000);
      drain("rnd_drain");

      // flush with 40 bytes queued
      for (int i = 0; i < 40; i++) begin
         in_avail = 1'b1;
         in_data  = 8'hC0 + i[7:0];
         tick();
      end
      check("pre_flush_level", level, 9'd40);
      sync     = 1'b0;
      out_next = 1'b1;
      settle();
      check("flush_in_next", in_next, 1'b0);
      tick();
      sync     = 1'b1;
      out_next = 1'b0;
      in_avail = 1'b0;
      check("flush_level", level,     9'd0);
      check("flush_avail", out_avail, 1'b0);
      check("flush_data",  out_data,  8'h00);
      in_avail = 1'b1;
      in_data  = 8'h3C;
      tick();
      in_avail = 1'b0;
      tick();
      tick();
      check("resync_avail", out_avail, 1'b1);
      check("resync_data",  out_data,  8'h3C);
      check("resync_level", level,     9'd1);
      out_next = 1'b1;
      tick();
      out_next = 1'b0;
      check("resync_drain", level, 9'd0);

      // async reset with 100 bytes queued
      for (int i = 0; i < 100; i++) begin
         in_avail = 1'b1;
         in_data  = 8'h80 ^ i[7:0];
         tick();
      end
      in_avail = 1'b0;
      check("pre_rst_level", level, 9'd100);
      #1;
      rst = 1'b0;
      #1;
      check("arst_level",   level,     9'd0);
      check("arst_avail",   out_avail, 1'b0);
      check("arst_data",    out_data,  8'h00);
      check("arst_hiwater", hiwater,   1'b0);
      check("arst_stall",   stall,     1'b0);
      #1;
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("post_rst_avail", out_avail, 1'b0);
         check("post_rst_level", level, 9'd0);
      end
      in_avail = 1'b1;
      in_data  = 8'h77;
      tick();
      in_avail = 1'b0;
      tick();
      tick();
      check("post_rst_first", out_data, 8'h77);
      check("post_rst_valid", out_avail, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/trace_tx_fifo.md
Name: trace_tx_fifo

Overview:
- Elastic byte buffer between the packet splitter (`packSend`) and the UART transmitter in the orbtrace datapath.
- Pulls decoded trace bytes from the splitter using its DataAvail/DataVal/DataNext pull handshake.
- Presents bytes to the UART as a first-word-fall-through (FWFT) source, and absorbs UART back-pressure so the splitter is not stalled by per-byte serial timing.
- Provides fill level, a high-water flag and a stretched stall indicator for an LED.

Parameters:
- DEPTH_LOG2, 8, log2 of FIFO depth (256 bytes); sized to map onto one iCE40 BRAM.
- HIWATER, 192, level at or above which hiwater asserts; legal range 1..2^DEPTH_LOG2.
- STRETCH_LOG2, 20, stall indicator hold time is 2^STRETCH_LOG2 clk cycles (~22 ms at 48 MHz).

Ports:
- clk  in  1  system clock, 48 MHz PLL output.
- rst  in  1  reset: asynchronous, active-low.
- sync  in  1  trace-sync indicator from the trace interface; low flushes the FIFO.
- in_avail  in  1  upstream has a byte on in_data.
- in_data  in  8  upstream byte.
- in_next  out  1  pull strobe to upstream; byte is consumed on this edge.
- out_avail  out  1  FIFO non-empty; out_data is valid.
- out_data  out  8  head-of-FIFO byte.
- out_next  in  1  pop strobe from the UART side (avail & tx_free).
- level  out  DEPTH_LOG2+1  current occupancy, 0..2^DEPTH_LOG2.
- hiwater  out  1  registered flag, level >= HIWATER.
- stall  out  1  stretched indicator: upstream was blocked by a full FIFO.

Behaviour:
- Reset (rst=0, asynchronous): read/write pointers = 0, level = 0, out_avail = 0, out_data = 0x00, hiwater = 0, stall = 0, stretch counter = 0. Reset mid-transfer discards all contents.
- in_next is combinational: in_avail & ~full & sync. On a clk edge with in_next=1:
  - in_data is written at the write pointer and the pointer increments, wrapping modulo 2^DEPTH_LOG2.
  - Upstream must present the next byte, or drop in_avail, by the following cycle.
  - Back-to-back writes every cycle are legal.
- full = (level == 2^DEPTH_LOG2). Extra wptr/rptr bit distinguishes full from empty.
- Memory uses a synchronous read port (BRAM inference). out_data is driven from a one-entry output register (FWFT):
  - When the output register is empty and the RAM holds data, a prefetch loads it.
  - From an empty FIFO, a byte written at edge N gives out_avail=1 with out_data=byte after edge N+2.
  - With out_next held high and data queued, one byte pops per cycle with no bubbles.
- out_next when out_avail=1: pops the head byte. out_next when out_avail=0: ignored, with no pointer or level change.
- level counts every byte accepted and not yet popped, including the byte in the output register.
  - Simultaneous push and pop: level unchanged.
  - Push when full: impossible, because in_next=0.
  - Pop at level 1 with a simultaneous push: out_avail stays 1 only if the latency rule allows; the bench must accept a one-cycle out_avail=0 bubble in this case only.
- hiwater: registered compare, one cycle after level changes.
- stall:
  - Any cycle with in_avail=1 & full=1 & sync=1 loads the stretch counter with 2^STRETCH_LOG2-1 and sets stall=1.
  - Otherwise the counter decrements while nonzero; stall=1 while the counter is nonzero.
  - A retrigger during a stretch reloads the counter.
- Flush (sync=0), evaluated each edge:
  - Pointers, level and output register are cleared, out_avail=0, in_next=0, and out_next is ignored.
  - stall is not cleared.
  - On the first edge after sync returns to 1, normal operation resumes from empty.
- Level wrap: pointers wrap at 2^DEPTH_LOG2. level never exceeds 2^DEPTH_LOG2 and never underflows below 0.
- No combinational path from out_next to in_next.

Test Plan:
- Reset and basic latency: rst low then high, sync=1; push 0xA5 at edge N -> out_avail=1 and out_data=0xA5 after edge N+2; level=1; pop -> out_avail=0, level=0.
- Streaming: push 0x00..0xFF continuously while popping every cycle -> output is the same ordered sequence with no gaps after the initial fill, and level stays constant.
- Fill to full: push 256 bytes with no pops -> level=256, in_next=0 with in_avail=1, hiwater=1 (from level 192), stall=1; pop one -> in_next reasserts next cycle; stall remains 1 for 2^STRETCH_LOG2 cycles after the last blocked cycle (use STRETCH_LOG2=4 in the bench: 16 cycles).
- Pointer wrap: 1000 random bytes with random in_avail/out_next duty (10–90%) -> scoreboard matches exactly; level always equals pushes minus pops.
- Flush: 40 bytes queued, drop sync for 1 cycle -> level=0, out_avail=0; in_next=0 during that cycle; after resync a new byte 0x3C emerges first.
- Async reset mid-stream: assert rst between clock edges with 100 bytes queued -> all outputs return to reset values immediately; no stale byte appears after release.
